// File: rtl/warp_controller.sv
// -----------------------------------------------------------------------------
// warp_controller
//
// Per-warp sequencing engine. Walks one warp through fetch, decode, operand
// request, optional LSU wait, execute and register update. Owns the warp PC,
// the retired-instruction counter and the kernel "done" flag. The register
// files use warp_state_o / enable_o to gate their reads and writebacks.
//
// Ports:
//   clk_i, reset_i             clock, asynchronous active-high reset
//   start_i, start_pc_i        kernel launch request and its entry PC
//   fetch_valid_o/fetch_ready_i  instruction fetch handshake for pc_o
//   decoded_*_i                decode results for the current instruction
//   branch_taken_i, branch_target_i  branch outcome, valid in EXECUTE
//   warp_execution_mask_i      active-lane mask
//   lsu_valid_o, lsu_done_i    LSU request strobe / completion
//   enable_o                   warp active (not IDLE, not DONE)
//   warp_state_o               current state encoding
//   pc_o                       current instruction address
//   done_o                     kernel finished, held until next launch
//   instr_count_o              retired instruction count (wraps)
// -----------------------------------------------------------------------------
module warp_controller #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_pc_i,
  output logic              fetch_valid_o,
  input  logic              fetch_ready_i,
  input  logic              decoded_mem_read_i,
  input  logic              decoded_mem_write_i,
  input  logic              decoded_ret_i,
  input  logic              decoded_branch_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [DATA_W-1:0] warp_execution_mask_i,
  output logic              lsu_valid_o,
  input  logic              lsu_done_i,
  output logic              enable_o,
  output logic [2:0]        warp_state_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              done_o,
  output logic [31:0]       instr_count_o
);

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_e;

  warp_state_e       state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              done_q;
  logic [31:0]       instr_count_q;
  logic              br_is_q;
  logic              br_taken_q;
  logic [ADDR_W-1:0] br_target_q;

  // A memory instruction with no active lanes never talks to the LSU.
  logic mem_access_d;
  assign mem_access_d = (decoded_mem_read_i | decoded_mem_write_i) &
                        (|warp_execution_mask_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= WARP_IDLE;
      pc_q          <= RESET_PC;
      done_q        <= 1'b0;
      instr_count_q <= '0;
      br_is_q       <= 1'b0;
      br_taken_q    <= 1'b0;
      br_target_q   <= '0;
    end else begin
      case (state_q)
        WARP_IDLE: begin
          if (start_i) begin
            pc_q          <= start_pc_i;
            done_q        <= 1'b0;
            instr_count_q <= '0;
            state_q       <= WARP_FETCH;
          end
        end
        WARP_FETCH: begin
          if (fetch_ready_i) state_q <= WARP_DECODE;
        end
        WARP_DECODE: state_q <= WARP_REQUEST;
        WARP_REQUEST: begin
          state_q <= mem_access_d ? WARP_WAIT : WARP_EXECUTE;
        end
        WARP_WAIT: begin
          if (lsu_done_i) state_q <= WARP_EXECUTE;
        end
        WARP_EXECUTE: begin
          // Branch outcome is only valid this cycle; hold it for UPDATE.
          br_is_q     <= decoded_branch_i;
          br_taken_q  <= branch_taken_i;
          br_target_q <= branch_target_i;
          state_q     <= WARP_UPDATE;
        end
        WARP_UPDATE: begin
          instr_count_q <= instr_count_q + 32'd1;
          if (decoded_ret_i) begin
            // done rises together with entry into DONE.
            done_q  <= 1'b1;
            state_q <= WARP_DONE;
          end else if (br_is_q && br_taken_q) begin
            pc_q    <= br_target_q;
            state_q <= WARP_FETCH;
          end else begin
            pc_q    <= pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_q <= WARP_FETCH;
          end
        end
        WARP_DONE: state_q <= WARP_IDLE;
        default:   state_q <= WARP_IDLE;
      endcase
    end
  end

  assign fetch_valid_o = (state_q == WARP_FETCH);
  assign lsu_valid_o   = (state_q == WARP_REQUEST) & mem_access_d;
  assign enable_o      = (state_q != WARP_IDLE) & (state_q != WARP_DONE);
  assign warp_state_o  = state_q;
  assign pc_o          = pc_q;
  assign done_o        = done_q;
  assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_warp_controller.sv
module tb_warp_controller;

  localparam int         AW     = 8;
  localparam int         DW     = 32;
  localparam logic [7:0] RST_PC = 8'h05;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_REQUEST = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_EXECUTE = 3'd5;
  localparam logic [2:0] S_UPDATE  = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          fetch_valid;
  logic          fetch_ready;
  logic          dec_rd, dec_wr, dec_ret, dec_br;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic [DW-1:0] mask;
  logic          lsu_valid;
  logic          lsu_done;
  logic          enable;
  logic [2:0]    warp_state;
  logic [AW-1:0] pc;
  logic          done;
  logic [31:0]   instr_count;

  warp_controller #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RST_PC)) dut (
    .clk_i                 (clk),
    .reset_i               (reset),
    .start_i               (start),
    .start_pc_i            (start_pc),
    .fetch_valid_o         (fetch_valid),
    .fetch_ready_i         (fetch_ready),
    .decoded_mem_read_i    (dec_rd),
    .decoded_mem_write_i   (dec_wr),
    .decoded_ret_i         (dec_ret),
    .decoded_branch_i      (dec_br),
    .branch_taken_i        (branch_taken),
    .branch_target_i       (branch_target),
    .warp_execution_mask_i (mask),
    .lsu_valid_o           (lsu_valid),
    .lsu_done_i            (lsu_done),
    .enable_o              (enable),
    .warp_state_o          (warp_state),
    .pc_o                  (pc),
    .done_o                (done),
    .instr_count_o         (instr_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One instruction as seen from outside: what it is and how the environment responds.
  typedef struct {
    int         mem;     // 0 none, 1 load, 2 store
    logic [31:0] msk;
    int         stall;   // cycles fetch_ready stays low in FETCH
    int         lsu_n;   // cycles of WAIT before lsu_done
    bit         br;
    bit         taken;
    logic [7:0] target;
    bit         ret;
  } instr_t;

  typedef struct {
    instr_t     in;
    logic [7:0] exp_pc;
    int         exp_lsu;
    int         exp_cycles;  // FETCH entry through UPDATE, inclusive
  } vec_t;

  // Reference model: the expected per-cycle state trace built from latency rules.
  logic [2:0] exp_q[$];

  task automatic model_seq(input instr_t in);
    exp_q.delete();
    repeat (in.stall + 1) exp_q.push_back(S_FETCH);
    exp_q.push_back(S_DECODE);
    exp_q.push_back(S_REQUEST);
    if (in.mem != 0 && in.msk != 0) repeat (in.lsu_n + 1) exp_q.push_back(S_WAIT);
    exp_q.push_back(S_EXECUTE);
    exp_q.push_back(S_UPDATE);
    if (in.ret) exp_q.push_back(S_DONE);
  endtask

  function automatic logic [7:0] model_pc(input instr_t in, input logic [7:0] cur);
    if (in.ret) return cur;
    if (in.br && in.taken) return in.target;
    return cur + 8'd1;
  endfunction

  // Called at a falling edge with the DUT expected in FETCH.
  task automatic run_instr(input instr_t in, input logic [7:0] pc0, input logic [31:0] cnt0,
                           input bit noise, input bit hold_start,
                           output int lsu_pulses, output int upd_cycles);
    logic [2:0] s;
    bit         last;
    bit         mem_on;
    model_seq(in);
    lsu_pulses = 0;
    upd_cycles = -1;
    mem_on  = (in.mem != 0) && (in.msk != 0);
    dec_rd  = (in.mem == 1);
    dec_wr  = (in.mem == 2);
    dec_br  = in.br;
    dec_ret = in.ret;
    mask    = in.msk;
    for (int k = 0; k < exp_q.size(); k++) begin
      s = exp_q[k];
      chk("state", 32'(warp_state), 32'(s));
      chk("pc", 32'(pc), 32'(pc0));
      chk("enable", 32'(enable), 32'(s != S_DONE));
      chk("fetch_valid", 32'(fetch_valid), 32'(s == S_FETCH));
      chk("lsu_valid", 32'(lsu_valid), 32'(s == S_REQUEST && mem_on));
      chk("done", 32'(done), 32'(s == S_DONE));
      chk("instr_count", instr_count, (s == S_DONE) ? cnt0 + 32'd1 : cnt0);
      if (lsu_valid) lsu_pulses++;
      if (warp_state == S_UPDATE && upd_cycles < 0) upd_cycles = k + 1;
      last = (k + 1 == exp_q.size()) || (exp_q[k+1] != s);
      fetch_ready   = (s == S_FETCH) ? last : 1'($urandom);
      lsu_done      = (s == S_WAIT)  ? last : 1'($urandom);
      branch_taken  = (s == S_EXECUTE) ? in.taken  : 1'($urandom);
      branch_target = (s == S_EXECUTE) ? in.target : 8'($urandom);
      if (s == S_DONE) start = hold_start;
      else             start = noise ? 1'($urandom) : 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    if (!hold_start) start = 1'b0;
    chk("end_state", 32'(warp_state), 32'(in.ret ? S_IDLE : S_FETCH));
    chk("end_pc", 32'(pc), 32'(model_pc(in, pc0)));
    chk("end_count", instr_count, cnt0 + 32'd1);
  endtask

  vec_t       vecs[12];
  instr_t     ri;
  logic [7:0] pc_cur;
  logic [31:0] cnt;
  int         lp, uc;

  function automatic instr_t mk(int mem, logic [31:0] msk, int stall, int lsu_n,
                                bit br, bit taken, logic [7:0] target, bit ret);
    instr_t r;
    r.mem = mem; r.msk = msk; r.stall = stall; r.lsu_n = lsu_n;
    r.br = br; r.taken = taken; r.target = target; r.ret = ret;
    return r;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // mem, mask, stall, lsu_n, br, taken, target, ret ; exp_pc, lsu pulses, cycles
    vecs[0]  = '{mk(0, 32'h0,        0, 0, 0, 0, 8'h00, 0), 8'h11, 0, 5};
    vecs[1]  = '{mk(1, 32'hFFFFFFFF, 0, 3, 0, 0, 8'h00, 0), 8'h12, 1, 9};
    vecs[2]  = '{mk(0, 32'h0,        0, 0, 1, 1, 8'h40, 0), 8'h40, 0, 5};
    vecs[3]  = '{mk(0, 32'h0,        0, 0, 1, 1, 8'h12, 0), 8'h12, 0, 5};
    vecs[4]  = '{mk(0, 32'h0,        0, 0, 1, 0, 8'h40, 0), 8'h13, 0, 5};
    vecs[5]  = '{mk(1, 32'h0,        0, 2, 0, 0, 8'h00, 0), 8'h14, 0, 5};
    vecs[6]  = '{mk(2, 32'h1,        2, 0, 0, 0, 8'h00, 0), 8'h15, 1, 8};
    vecs[7]  = '{mk(0, 32'h0,        0, 0, 0, 1, 8'h77, 0), 8'h16, 0, 5};
    vecs[8]  = '{mk(0, 32'h0,        0, 0, 1, 1, 8'hFF, 0), 8'hFF, 0, 5};
    vecs[9]  = '{mk(0, 32'h0,        0, 0, 0, 0, 8'h00, 0), 8'h00, 0, 5};
    vecs[10] = '{mk(0, 32'h0,        0, 0, 1, 1, 8'h20, 0), 8'h20, 0, 5};
    vecs[11] = '{mk(0, 32'h0,        0, 0, 0, 0, 8'h00, 1), 8'h20, 0, 5};

    reset = 1'b1; start = 1'b0; start_pc = '0; fetch_ready = 1'b0;
    dec_rd = 1'b0; dec_wr = 1'b0; dec_ret = 1'b0; dec_br = 1'b0;
    branch_taken = 1'b0; branch_target = '0; mask = '0; lsu_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(warp_state), 32'(S_IDLE));
    chk("rst_pc", 32'(pc), 32'(RST_PC));
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold", 32'(warp_state), 32'(S_IDLE));

    // Directed table.
    start = 1'b1; start_pc = 8'h10;
    @(negedge clk);
    start = 1'b0;
    pc_cur = 8'h10; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i].in, pc_cur, cnt, 1'b0, 1'b0, lp, uc);
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d_lsu_pulses", i), 32'(lp), 32'(vecs[i].exp_lsu));
      chk($sformatf("vec%0d_cycles", i), 32'(uc), 32'(vecs[i].exp_cycles));
      $display("vec %0d: pc 0x%0h -> 0x%0h cycles=%0d lsu_pulses=%0d", i, pc_cur, pc, uc, lp);
      pc_cur = vecs[i].exp_pc;
      cnt = cnt + 1;
    end

    // After ret: done sticks in IDLE until a new launch.
    @(negedge clk);
    chk("post_ret_state", 32'(warp_state), 32'(S_IDLE));
    chk("post_ret_done", 32'(done), 32'd1);
    chk("post_ret_enable", 32'(enable), 32'd0);
    chk("post_ret_pc", 32'(pc), 32'h20);
    start = 1'b1; start_pc = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    chk("relaunch_state", 32'(warp_state), 32'(S_FETCH));
    chk("relaunch_done", 32'(done), 32'd0);
    chk("relaunch_count", instr_count, 32'd0);
    chk("relaunch_pc", 32'(pc), 32'(start_pc));
    $display("relaunch: pc=0x%0h done=%0d", pc, done);

    // Randomized instructions against the model.
    pc_cur = start_pc; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      ri = mk(int'($urandom_range(0, 2)),
              ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom | 32'h1),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
      run_instr(ri, pc_cur, cnt, 1'b1, 1'b0, lp, uc);
      $display("rand %0d: mem=%0d mask=0x%0h br=%0d tk=%0d pc 0x%0h -> 0x%0h",
               i, ri.mem, ri.msk, ri.br, ri.taken, pc_cur, pc);
      pc_cur = model_pc(ri, pc_cur);
      cnt = cnt + 1;
    end

    // ret with start held high through DONE: relaunch one cycle after DONE.
    start_pc = 8'h33;
    ri = mk(0, 32'h0, 0, 0, 0, 0, 8'h00, 1);
    run_instr(ri, pc_cur, cnt, 1'b1, 1'b1, lp, uc);
    chk("held_start_idle_done", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("held_start_state", 32'(warp_state), 32'(S_FETCH));
    chk("held_start_pc", 32'(pc), 32'h33);
    chk("held_start_done", 32'(done), 32'd0);
    $display("held start relaunch: state=%0d pc=0x%0h", warp_state, pc);

    // Asynchronous reset in the middle of an LSU wait.
    dec_rd = 1'b1; dec_wr = 1'b0; dec_ret = 1'b0; dec_br = 1'b0;
    mask = 32'hFFFFFFFF; fetch_ready = 1'b1; lsu_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_wait", 32'(warp_state), 32'(S_WAIT));
    @(negedge clk);
    chk("pre_reset_wait2", 32'(warp_state), 32'(S_WAIT));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(warp_state), 32'(S_IDLE));
    chk("async_rst_pc", 32'(pc), 32'(RST_PC));
    chk("async_rst_lsu_valid", 32'(lsu_valid), 32'd0);
    chk("async_rst_enable", 32'(enable), 32'd0);
    chk("async_rst_count", instr_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    lsu_done = 1'b1;
    @(negedge clk);
    lsu_done = 1'b0;
    @(negedge clk);
    chk("late_lsu_done_state", 32'(warp_state), 32'(S_IDLE));
    chk("late_lsu_done_pc", 32'(pc), 32'(RST_PC));
    chk("late_lsu_done_lsu_valid", 32'(lsu_valid), 32'd0);
    $display("async reset mid-wait: state=%0d pc=0x%0h", warp_state, pc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/warp_controller.md
# warp_controller

Per-warp sequencing engine that drives the warp pipeline through fetch, decode, operand request, memory wait, execute and register update. It sits directly upstream of the scalar and vector register files: it produces the `warp_state` and `enable` they use to gate reads and writebacks, and it owns the warp program counter. It also handshakes with the instruction fetcher and the LSU, and reports kernel completion to the core.

## Interface
- `RESET_PC`, default `0`: program counter value loaded by reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: level-sensitive kernel launch request; sampled only in `WARP_IDLE`.
- `start_pc` in `instruction_memory_address_t`: PC loaded when `start` is accepted.
- `fetch_valid` out 1: instruction fetch request for the current `pc`.
- `fetch_ready` in 1: fetcher has the instruction for `pc` available this cycle.
- `decoded_mem_read` in 1: current instruction is a load.
- `decoded_mem_write` in 1: current instruction is a store.
- `decoded_ret` in 1: current instruction terminates the warp.
- `decoded_branch` in 1: current instruction is a branch or jump.
- `branch_taken` in 1: branch condition result, valid in `WARP_EXECUTE`.
- `branch_target` in `instruction_memory_address_t`: target PC, valid in `WARP_EXECUTE`.
- `warp_execution_mask` in `data_t`: active-lane mask from the scalar register file.
- `lsu_valid` out 1: LSU request strobe.
- `lsu_done` in 1: LSU has completed the request for every active lane.
- `enable` out 1: warp active; drives the register-file `enable`.
- `warp_state` out `warp_state_t`: current state.
- `pc` out `instruction_memory_address_t`: current instruction address.
- `done` out 1: kernel finished; stays high until the next `start` is accepted.
- `instr_count` out 32: number of retired instructions, wraps at 2^32.

## Operation
- States: `WARP_IDLE`, `WARP_FETCH`, `WARP_DECODE`, `WARP_REQUEST`, `WARP_WAIT`, `WARP_EXECUTE`, `WARP_UPDATE`, `WARP_DONE`.
- `WARP_IDLE`: if `start=1`, then `pc <= start_pc`, `done <= 0`, `instr_count <= 0`, next state `WARP_FETCH`.
- `WARP_FETCH`: `fetch_valid=1`. Advance to `WARP_DECODE` on the edge where `fetch_ready=1`; otherwise hold.
- `WARP_DECODE`: one cycle, then `WARP_REQUEST`.
- `WARP_REQUEST`: one cycle; the register files sample operands here.
  - If (`decoded_mem_read` or `decoded_mem_write`) and `warp_execution_mask != 0`: `lsu_valid=1` for this cycle only, next state `WARP_WAIT`.
  - Otherwise next state `WARP_EXECUTE`.
- `WARP_WAIT`: hold until `lsu_done=1`, then `WARP_EXECUTE`. A `lsu_done` seen in any other state is ignored.
- `WARP_EXECUTE`: one cycle. Latch `branch_taken` and `branch_target` into internal registers. Next state `WARP_UPDATE`.
- `WARP_UPDATE`: one cycle; the register files write back here. `instr_count` increments.
  - If `decoded_ret`: next state `WARP_DONE`, `pc` unchanged.
  - Else if the latched `decoded_branch` and `branch_taken` are both set: `pc <= latched branch_target`, next state `WARP_FETCH`.
  - Otherwise `pc <= pc + 1` (wraps modulo address width), next state `WARP_FETCH`.
- `WARP_DONE`: `done=1`, next state `WARP_IDLE` on the following cycle. `done` remains 1 in `WARP_IDLE` until `start` is accepted.
- `enable` = 1 in every state except `WARP_IDLE` and `WARP_DONE`.
- Mask of zero on a memory instruction: the LSU is skipped, and the instruction still retires and advances `pc`.
- Illegal or unknown state value: forces `WARP_IDLE`.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-instruction):
  - `warp_state=WARP_IDLE`, `pc=RESET_PC`, `done=0`, `instr_count=0`.
  - `fetch_valid=0`, `lsu_valid=0`, `enable=0`; latched branch registers cleared.
  - Any outstanding LSU or fetch transaction is abandoned.
- Outputs are combinational decodes of the registered state, except `pc`, `done` and `instr_count`, which are registered.
- Minimum instruction latency, from entering `WARP_FETCH` to the next `WARP_FETCH`, with `fetch_ready` already high and no memory access: 5 cycles (FETCH, DECODE, REQUEST, EXECUTE, UPDATE).
- A memory instruction adds 1 + N cycles, where N is the number of cycles until `lsu_done`; `lsu_done` asserted in the first `WARP_WAIT` cycle gives N=0.
- `start` held high through `WARP_DONE` relaunches the kernel from `WARP_IDLE` one cycle after `WARP_DONE`.
- `start` in any state other than `WARP_IDLE` is ignored.

## Test plan
- Reset, then `start=1` with `start_pc=0x10` and `fetch_ready=1`, no memory, no branch:
  - `warp_state` sequence is FETCH, DECODE, REQUEST, EXECUTE, UPDATE, FETCH.
  - `pc` reads 0x11 in the second FETCH; `instr_count=1`.
- Load with mask `0xFFFFFFFF` and `lsu_done` delayed 3 cycles:
  - `lsu_valid` is high for exactly 1 cycle in REQUEST.
  - The warp stays in WAIT for 4 cycles, then EXECUTE.
- Load with mask `0`: no `lsu_valid`, WAIT is skipped, `pc` advances by 1.
- Branch taken to 0x40, issued at pc 0x12: next FETCH has `pc=0x40`. With `branch_taken=0`, the next FETCH has `pc=0x13`.
- `ret` at pc 0x20:
  - Sequence UPDATE, DONE, IDLE.
  - `done=1` from DONE onward, `enable=0`, `pc` stays 0x20.
  - A new `start` clears `done`.
- Reset asserted mid-WAIT, between clock edges:
  - `warp_state=IDLE`, `pc=RESET_PC` and `lsu_valid=0` immediately, before the next edge.
  - A later `lsu_done` pulse has no effect.
